control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/control_unit_if.sv | 26 ++
 rtl/control_unit_op_decode.sv | 33 +++
 rtl/control_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-unit states, opcode map, ALU codes and
// the packed control word driven towards the datapath.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_TWO, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_OR   = 5'b00010;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_SHR  = 5'b00101;
  localparam logic [4:0] ALU_SHL  = 5'b00110;
  localparam logic [4:0] ALU_ROR  = 5'b00111;
  localparam logic [4:0] ALU_ROL  = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b01001;
  localparam logic [4:0] ALU_DIV  = 5'b01010;
  localparam logic [4:0] ALU_NEG  = 5'b01011;
  localparam logic [4:0] ALU_NOT  = 5'b01100;

  typedef struct packed {
    logic       pc_out;
    logic       zlo_out;
    logic       zhi_out;
    logic       mdr_out;
    logic       r_out;
    logic       pc_in;
    logic       mar_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       z_in;
    logic       hi_in;
    logic       lo_in;
    logic       r_in;
    logic       inc_pc;
    logic       read;
    logic       gra;
    logic       grb;
    logic       grc;
    logic [4:0] alu;
    logic       run;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle. The control unit is the master: it
// drives every enable and receives IR and the Stop request.
interface control_unit_if;
  logic        Stop;
  logic [31:0] IR;
  logic        PCout, ZLOout, ZHIout, MDRout, Rout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
  logic        IncrementPC, Read;
  logic        Gra, Grb, Grc;
  logic [4:0]  ALUControl;
  logic        Run;

  modport master (
    input  Stop, IR,
    output PCout, ZLOout, ZHIout, MDRout, Rout,
           PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
           IncrementPC, Read, Gra, Grb, Grc, ALUControl, Run
  );

  modport slave (
    output Stop, IR,
    input  PCout, ZLOout, ZHIout, MDRout, Rout,
           PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
           IncrementPC, Read, Gra, Grb, Grc, ALUControl, Run
  );
endinterface

// File: rtl/control_unit_op_decode.sv
// Combinational opcode decode: instruction class plus the ALU operation
// the execute states should request.
module op_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [4:0] alu_code
);

  always_comb begin
    op_class = CLS_NOP;
    alu_code = ALU_NONE;
    case (opcode)
      OP_ADD:  begin op_class = CLS_TWO;    alu_code = ALU_ADD; end
      OP_SUB:  begin op_class = CLS_TWO;    alu_code = ALU_SUB; end
      OP_AND:  begin op_class = CLS_TWO;    alu_code = ALU_AND; end
      OP_OR:   begin op_class = CLS_TWO;    alu_code = ALU_OR;  end
      OP_SHR:  begin op_class = CLS_TWO;    alu_code = ALU_SHR; end
      OP_SHL:  begin op_class = CLS_TWO;    alu_code = ALU_SHL; end
      OP_ROR:  begin op_class = CLS_TWO;    alu_code = ALU_ROR; end
      OP_ROL:  begin op_class = CLS_TWO;    alu_code = ALU_ROL; end
      OP_MUL:  begin op_class = CLS_MULDIV; alu_code = ALU_MUL; end
      OP_DIV:  begin op_class = CLS_MULDIV; alu_code = ALU_DIV; end
      OP_NEG:  begin op_class = CLS_UNARY;  alu_code = ALU_NEG; end
      OP_NOT:  begin op_class = CLS_UNARY;  alu_code = ALU_NOT; end
      OP_HALT: op_class = CLS_HALT;
      // nop and every unlisted opcode fall through as a no-op
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: fetch (T0-T2) then class-dependent execute (T3-T6).
// Outputs decode from the present state and IR, which is valid from T3.
module control_unit
  import cpu_pkg::*;
#(
  parameter int IR_W = 32
) (
  input  logic          Clock,
  input  logic          Reset,
  control_unit_if.master bus
);

  state_t     state_q, state_d;
  op_class_t  op_class;
  logic [4:0] alu_code;
  ctrl_t      ctrl;
  logic [IR_W-1:0] ir;
  logic       unused_ir_fields;

  assign ir = bus.IR;
  // register fields are consumed downstream through Gra/Grb/Grc
  assign unused_ir_fields = ^ir[IR_W-6:0];

  op_decode u_dec (
    .opcode   (ir[IR_W-1:IR_W-5]),
    .op_class (op_class),
    .alu_code (alu_code)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_T0:   state_d = bus.Stop ? ST_HALT : ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:
        case (op_class)
          CLS_TWO, CLS_MULDIV, CLS_UNARY: state_d = ST_T4;
          CLS_HALT:                       state_d = ST_HALT;
          default:                        state_d = ST_T0;
        endcase
      ST_T4:   state_d = (op_class == CLS_UNARY) ? ST_T0 : ST_T5;
      ST_T5:   state_d = (op_class == CLS_MULDIV) ? ST_T6 : ST_T0;
      ST_T6:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_T0;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl     = '0;
    ctrl.run = (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1; ctrl.z_in   = 1'b1;
      end
      ST_T1: begin
        ctrl.zlo_out = 1'b1; ctrl.pc_in  = 1'b1;
        ctrl.read    = 1'b1; ctrl.mdr_in = 1'b1;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      ST_T3:
        case (op_class)
          CLS_TWO, CLS_MULDIV: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
          end
          CLS_UNARY: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
            ctrl.alu = alu_code;
          end
          default: ;
        endcase
      ST_T4:
        case (op_class)
          CLS_TWO, CLS_MULDIV: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
            ctrl.alu = alu_code;
          end
          CLS_UNARY: begin
            ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          default: ;
        endcase
      ST_T5:
        case (op_class)
          CLS_TWO: begin
            ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1;
          end
          default: ;
        endcase
      ST_T6:
        if (op_class == CLS_MULDIV) begin
          ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1;
        end
      default: ;
    endcase
  end

  assign bus.PCout       = ctrl.pc_out;
  assign bus.ZLOout      = ctrl.zlo_out;
  assign bus.ZHIout      = ctrl.zhi_out;
  assign bus.MDRout      = ctrl.mdr_out;
  assign bus.Rout        = ctrl.r_out;
  assign bus.PCin        = ctrl.pc_in;
  assign bus.MARin       = ctrl.mar_in;
  assign bus.MDRin       = ctrl.mdr_in;
  assign bus.IRin        = ctrl.ir_in;
  assign bus.Yin         = ctrl.y_in;
  assign bus.Zin         = ctrl.z_in;
  assign bus.HIin        = ctrl.hi_in;
  assign bus.LOin        = ctrl.lo_in;
  assign bus.Rin         = ctrl.r_in;
  assign bus.IncrementPC = ctrl.inc_pc;
  assign bus.Read        = ctrl.read;
  assign bus.Gra         = ctrl.gra;
  assign bus.Grb         = ctrl.grb;
  assign bus.Grc         = ctrl.grc;
  assign bus.ALUControl  = ctrl.alu;
  assign bus.Run         = ctrl.run;

endmodule
